// File: rtl/pcie_dma_pkg.sv
// Shared types and constants for the PCIe DMA AXIMM write path.
package pcie_dma_pkg;

    localparam int BEAT_BYTES = 16;
    localparam int RQ_ADDR_W  = 64;
    localparam int RQ_DATA_W  = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        CHK,
        DONE
    } WrSeqState;

endpackage

// File: rtl/pcie_wr_seq.sv
// Write-request sequencer: splits one descriptor into 16-byte single-beat
// requests for the AXI write controller and tallies error completions.
module pcie_wr_seq
    import pcie_dma_pkg::*;
#(
    parameter int LEN_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 DescValid,
    input  logic [RQ_ADDR_W-1:0] DescAddr,
    input  logic [LEN_W-1:0]     DescLen,
    output logic                 DescReady,
    input  logic                 DinValid,
    input  logic [RQ_DATA_W-1:0] DinData,
    output logic                 DinReady,
    output logic                 RqValid,
    output logic [RQ_ADDR_W-1:0] RqAddr,
    output logic [RQ_DATA_W-1:0] RqData,
    input  logic                 RqReady,
    input  logic                 RqErr,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Aborted,
    output logic [LEN_W-1:0]     ErrCnt
);

    WrSeqState state, state_nxt;

    logic [RQ_ADDR_W-1:0] addr_q;
    logic [RQ_DATA_W-1:0] data_q;
    logic [LEN_W-1:0]     remain_q;
    logic [LEN_W-1:0]     err_cnt_q;
    logic                 aborted_q;
    logic                 last_beat;
    logic                 stop_now;

    // Exit test looks at the count before the decrement so Remain never wraps.
    assign last_beat = (remain_q == LEN_W'(1));
    assign stop_now  = STOP_ON_ERR && RqErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default-first assignment keeps this block free of inferred latches.
        state_nxt = state;
        case (state)
            IDLE:    if (DescValid) state_nxt = (DescLen == '0) ? DONE : LOAD;
            LOAD:    if (DinValid)  state_nxt = ISSUE;
            ISSUE:   if (RqReady)   state_nxt = CHK;
            CHK:     state_nxt = (last_beat || stop_now) ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register, so RqValid
    // drops asynchronously with reset and is guaranteed low during CHK.
    always_comb begin
        DescReady = 1'b0;
        DinReady  = 1'b0;
        RqValid   = 1'b0;
        Done      = 1'b0;
        Busy      = (state != IDLE);
        case (state)
            IDLE:    DescReady = 1'b1;
            LOAD:    DinReady  = 1'b1;
            ISSUE:   RqValid   = 1'b1;
            DONE:    Done      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            data_q    <= '0;
            remain_q  <= '0;
            err_cnt_q <= '0;
            aborted_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (DescValid) begin
                        addr_q    <= {DescAddr[RQ_ADDR_W-1:4], 4'h0};
                        remain_q  <= DescLen;
                        err_cnt_q <= '0;
                        aborted_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (DinValid) data_q <= DinData;
                end
                CHK: begin
                    addr_q   <= addr_q + RQ_ADDR_W'(BEAT_BYTES);
                    remain_q <= remain_q - LEN_W'(1);
                    if (RqErr && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + LEN_W'(1);
                    // An error on the final beat is a normal finish, not an abort.
                    if (stop_now && !last_beat) aborted_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign RqAddr  = addr_q;
    assign RqData  = data_q;
    assign ErrCnt  = err_cnt_q;
    assign Aborted = aborted_q;

endmodule

// File: tb/tb_pcie_wr_seq.sv
// Directed bench for pcie_wr_seq: one instance per STOP_ON_ERR setting,
// a small cycle-driven controller responder, and per-scenario checks.
module tb_pcie_wr_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         desc_valid;
    logic [63:0]  desc_addr;
    logic [15:0]  desc_len;
    logic         din_valid;
    logic [127:0] din_data;
    logic         rq_ready;
    logic         rq_err;
    logic         sel;

    logic         desc_ready0, din_ready0, rq_valid0, busy0, done0, aborted0;
    logic [63:0]  rq_addr0;
    logic [127:0] rq_data0;
    logic [15:0]  err_cnt0;
    logic         desc_ready1, din_ready1, rq_valid1, busy1, done1, aborted1;
    logic [63:0]  rq_addr1;
    logic [127:0] rq_data1;
    logic [15:0]  err_cnt1;

    logic         desc_ready, din_ready, rq_valid, busy, done, aborted;
    logic [63:0]  rq_addr;
    logic [127:0] rq_data;
    logic [15:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    int           n_req, n_done, done_cyc, acc_cyc, first_rqv, rqv_cycles;
    logic         din_seen, unstable, rst_hit, busy_at_done, busy_after, drdy_after;
    logic [15:0]  err_before;
    logic [63:0]  req_addr [8];
    logic [127:0] req_data [8];

    always #5 clk = ~clk;

    pcie_wr_seq #(.LEN_W(16), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .DescValid(desc_valid), .DescAddr(desc_addr), .DescLen(desc_len), .DescReady(desc_ready0),
        .DinValid(din_valid), .DinData(din_data), .DinReady(din_ready0),
        .RqValid(rq_valid0), .RqAddr(rq_addr0), .RqData(rq_data0),
        .RqReady(rq_ready), .RqErr(rq_err),
        .Busy(busy0), .Done(done0), .Aborted(aborted0), .ErrCnt(err_cnt0)
    );

    pcie_wr_seq #(.LEN_W(16), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .DescValid(desc_valid), .DescAddr(desc_addr), .DescLen(desc_len), .DescReady(desc_ready1),
        .DinValid(din_valid), .DinData(din_data), .DinReady(din_ready1),
        .RqValid(rq_valid1), .RqAddr(rq_addr1), .RqData(rq_data1),
        .RqReady(rq_ready), .RqErr(rq_err),
        .Busy(busy1), .Done(done1), .Aborted(aborted1), .ErrCnt(err_cnt1)
    );

    assign desc_ready = sel ? desc_ready1 : desc_ready0;
    assign din_ready  = sel ? din_ready1  : din_ready0;
    assign rq_valid   = sel ? rq_valid1   : rq_valid0;
    assign busy       = sel ? busy1       : busy0;
    assign done       = sel ? done1       : done0;
    assign aborted    = sel ? aborted1    : aborted0;
    assign rq_addr    = sel ? rq_addr1    : rq_addr0;
    assign rq_data    = sel ? rq_data1    : rq_data0;
    assign err_cnt    = sel ? err_cnt1    : err_cnt0;

    task automatic clear_inputs();
        desc_valid = 1'b0;
        desc_addr  = '0;
        desc_len   = '0;
        din_valid  = 1'b0;
        din_data   = '0;
        rq_ready   = 1'b0;
        rq_err     = 1'b0;
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one descriptor cycle by cycle, modelling the write controller:
    // RqReady after 'lat' cycles of RqValid, RqErr from err_mask in the CHK cycle.
    // Data beat k is 0xA+k, offered 'gap' cycles after the previous accept.
    // rst_req>0 asserts rst_n mid-ISSUE of that request and returns in reset.
    task automatic run_desc(input logic [63:0] addr, input logic [15:0] len,
                            input logic [7:0] err_mask, input int gap,
                            input int lat, input int rst_req);
        int   beat, gap_left, hi_cnt;
        logic take_desc, take_din, was_valid, finished;
        logic [63:0]  held_addr;
        logic [127:0] held_data;
        n_req = 0; n_done = 0; done_cyc = -1; acc_cyc = -1; first_rqv = -1; rqv_cycles = 0;
        din_seen = 0; unstable = 0; rst_hit = 0; busy_at_done = 0; busy_after = 1; drdy_after = 0;
        err_before = '0;
        beat = 0; gap_left = 0; hi_cnt = 0;
        take_desc = 0; take_din = 0; was_valid = 0; finished = 0;
        held_addr = '0; held_data = '0;
        desc_valid = 1'b1; desc_addr = addr; desc_len = len;
        din_valid = 1'b0; rq_ready = 1'b0; rq_err = 1'b0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = busy; drdy_after = desc_ready; finished = 1;
            end
            if (din_ready) din_seen = 1;
            if (rq_valid) begin
                rqv_cycles++;
                if (!was_valid) begin
                    if (n_req < 8) begin req_addr[n_req] = rq_addr; req_data[n_req] = rq_data; end
                    n_req++;
                    if (first_rqv < 0) first_rqv = cyc;
                    held_addr = rq_addr; held_data = rq_data; hi_cnt = 0;
                    if (n_req == rst_req) begin
                        err_before = err_cnt;
                        rst_hit = 1;
                        #2 rst_n = 1'b0;
                        clear_inputs();
                        return;
                    end
                end else if (rq_addr !== held_addr || rq_data !== held_data) begin
                    unstable = 1;
                end
                hi_cnt++;
                if (hi_cnt == lat) rq_ready = 1'b1;
            end
            was_valid = rq_valid;
            if (desc_valid && desc_ready) begin take_desc = 1; acc_cyc = cyc; end
            if (beat < int'(len)) begin
                if (gap_left == 0) din_valid = 1'b1;
                else begin din_valid = 1'b0; gap_left--; end
            end else begin
                din_valid = 1'b0;
            end
            din_data = 128'hA + 128'(beat);
            if (din_valid && din_ready) take_din = 1;
            @(posedge clk);
            #1;
            if (take_desc) begin desc_valid = 1'b0; take_desc = 0; end
            if (take_din) begin take_din = 0; beat++; gap_left = gap; end
            rq_err = 1'b0;
            if (rq_ready) begin rq_ready = 1'b0; rq_err = err_mask[n_req-1]; end
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++; if (desc_ready !== 1'b1) begin errors++; $display("FAIL reset_desc_ready[%0d]: got %b expected 1", s, desc_ready); end
            checks++; if ({rq_valid, din_ready, busy, done, aborted} !== 5'b0) begin errors++; $display("FAIL reset_flags[%0d]: got %b expected 00000", s, {rq_valid, din_ready, busy, done, aborted}); end
            checks++; if (rq_addr !== 64'h0 || rq_data !== 128'h0 || err_cnt !== 16'h0) begin errors++; $display("FAIL reset_regs[%0d]: got addr=%h data=%h err=%h expected zeros", s, rq_addr, rq_data, err_cnt); end
        end
        sel = 1'b0;
        do_reset();
    endtask

    task automatic test_basic();
        sel = 1'b0;
        do_reset();
        run_desc(64'h1000_0008, 16'd3, 8'h00, 0, 1, 0);
        checks++; if (n_req !== 3) begin errors++; $display("FAIL basic_nreq: got %0d expected 3", n_req); end
        checks++; if (req_addr[0] !== 64'h1000_0000 || req_addr[1] !== 64'h1000_0010 || req_addr[2] !== 64'h1000_0020) begin errors++; $display("FAIL basic_addr: got %h %h %h expected 10000000 10000010 10000020", req_addr[0], req_addr[1], req_addr[2]); end
        checks++; if (req_data[0] !== 128'hA || req_data[1] !== 128'hB || req_data[2] !== 128'hC) begin errors++; $display("FAIL basic_data: got %h %h %h expected A B C", req_data[0], req_data[1], req_data[2]); end
        checks++; if (first_rqv - acc_cyc !== 2) begin errors++; $display("FAIL basic_first_latency: got %0d expected 2", first_rqv - acc_cyc); end
        checks++; if (n_done !== 1 || done_cyc - acc_cyc !== 10) begin errors++; $display("FAIL basic_done: got count=%0d at=%0d expected count=1 at=10", n_done, done_cyc - acc_cyc); end
        checks++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0 || drdy_after !== 1'b1) begin errors++; $display("FAIL basic_busy: got done_busy=%b after_busy=%b after_ready=%b expected 1 0 1", busy_at_done, busy_after, drdy_after); end
        checks++; if (err_cnt !== 16'd0 || aborted !== 1'b0 || rqv_cycles !== 3) begin errors++; $display("FAIL basic_status: got err=%0d abort=%b rqv=%0d expected 0 0 3", err_cnt, aborted, rqv_cycles); end
    endtask

    task automatic test_zero_len();
        sel = 1'b0;
        do_reset();
        run_desc(64'h0000_4000, 16'd0, 8'h00, 0, 1, 0);
        checks++; if (n_done !== 1 || done_cyc - acc_cyc !== 1) begin errors++; $display("FAIL zero_done: got count=%0d at=%0d expected count=1 at=1", n_done, done_cyc - acc_cyc); end
        checks++; if (n_req !== 0 || din_seen !== 1'b0) begin errors++; $display("FAIL zero_no_traffic: got nreq=%0d din_ready_seen=%b expected 0 0", n_req, din_seen); end
    endtask

    task automatic test_err_continue();
        sel = 1'b0;
        do_reset();
        run_desc(64'h2000_0000, 16'd4, 8'b0000_0010, 0, 1, 0);
        checks++; if (n_req !== 4 || req_addr[3] !== 64'h2000_0030) begin errors++; $display("FAIL errc_nreq: got %0d last=%h expected 4 20000030", n_req, req_addr[3]); end
        checks++; if (err_cnt !== 16'd1 || aborted !== 1'b0) begin errors++; $display("FAIL errc_status: got err=%0d abort=%b expected 1 0", err_cnt, aborted); end
        checks++; if (n_done !== 1 || done_cyc - acc_cyc !== 13) begin errors++; $display("FAIL errc_done: got count=%0d at=%0d expected count=1 at=13", n_done, done_cyc - acc_cyc); end
    endtask

    task automatic test_err_stop();
        sel = 1'b1;
        do_reset();
        run_desc(64'h2000_0000, 16'd4, 8'b0000_0010, 0, 1, 0);
        checks++; if (n_req !== 2) begin errors++; $display("FAIL errs_nreq: got %0d expected 2", n_req); end
        checks++; if (err_cnt !== 16'd1 || aborted !== 1'b1) begin errors++; $display("FAIL errs_status: got err=%0d abort=%b expected 1 1", err_cnt, aborted); end
        checks++; if (n_done !== 1 || done_cyc - acc_cyc !== 7) begin errors++; $display("FAIL errs_done: got count=%0d at=%0d expected count=1 at=7", n_done, done_cyc - acc_cyc); end
        // Next descriptor must clear the sticky abort and the counter on accept.
        run_desc(64'h3000_0000, 16'd1, 8'h00, 0, 1, 0);
        checks++; if (aborted !== 1'b0 || err_cnt !== 16'd0 || n_req !== 1) begin errors++; $display("FAIL errs_clear: got abort=%b err=%0d nreq=%0d expected 0 0 1", aborted, err_cnt, n_req); end
        sel = 1'b0;
    endtask

    task automatic test_wrap_gap();
        sel = 1'b0;
        do_reset();
        run_desc(64'hFFFF_FFFF_FFFF_FFF0, 16'd2, 8'h00, 5, 3, 0);
        checks++; if (n_req !== 2 || req_addr[0] !== 64'hFFFF_FFFF_FFFF_FFF0 || req_addr[1] !== 64'h0) begin errors++; $display("FAIL wrap_addr: got n=%0d %h %h expected 2 fffffffffffffff0 0", n_req, req_addr[0], req_addr[1]); end
        checks++; if (req_data[0] !== 128'hA || req_data[1] !== 128'hB) begin errors++; $display("FAIL wrap_data: got %h %h expected A B", req_data[0], req_data[1]); end
        checks++; if (rqv_cycles !== 6 || unstable !== 1'b0) begin errors++; $display("FAIL gap_hold: got rqv_cycles=%0d unstable=%b expected 6 0", rqv_cycles, unstable); end
        checks++; if (n_done !== 1 || done_cyc - acc_cyc !== 12) begin errors++; $display("FAIL gap_done: got count=%0d at=%0d expected count=1 at=12", n_done, done_cyc - acc_cyc); end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        do_reset();
        run_desc(64'h5000_0000, 16'd3, 8'b0000_0001, 0, 2, 2);
        #1;
        checks++; if (rst_hit !== 1'b1 || err_before !== 16'd1) begin errors++; $display("FAIL rstmid_reached: got hit=%b err=%0d expected 1 1", rst_hit, err_before); end
        checks++; if (rq_valid !== 1'b0 || busy !== 1'b0 || desc_ready !== 1'b1 || err_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_async: got rqv=%b busy=%b ready=%b err=%0d expected 0 0 1 0", rq_valid, busy, desc_ready, err_cnt); end
        do_reset();
        run_desc(64'h6000_0000, 16'd1, 8'h00, 0, 1, 0);
        checks++; if (n_req !== 1 || req_addr[0] !== 64'h6000_0000 || err_cnt !== 16'd0 || n_done !== 1 || done_cyc - acc_cyc !== 4) begin errors++; $display("FAIL rstmid_restart: got n=%0d addr=%h err=%0d done=%0d at=%0d expected 1 60000000 0 1 4", n_req, req_addr[0], err_cnt, n_done, done_cyc - acc_cyc); end
    endtask

    initial begin
        sel = 1'b0;
        clear_inputs();
        test_reset();
        test_basic();
        test_zero_len();
        test_err_continue();
        test_err_stop();
        test_wrap_gap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
